// File: rtl/rat_pkg.sv
// Shared types and sizing for the RAT fetch path: PC source select, fetch FSM states
// and the default address/instruction widths and interrupt vector.
package rat_pkg;

    localparam int unsigned RAT_ADDR_W  = 10;
    localparam int unsigned RAT_INSTR_W = 18;
    localparam logic [RAT_ADDR_W-1:0] RAT_INTR_VECTOR = 10'h3FF;

    typedef enum logic [1:0] {
        PC_SEL_IMMED  = 2'd0,
        PC_SEL_STACK  = 2'd1,
        PC_SEL_VECTOR = 2'd2,
        PC_SEL_HOLD   = 2'd3
    } pc_sel_t;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_INTR   = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// PC register: load (from the selected source) beats increment; neither holds.
// Next-PC is exported so the caller can capture the post-update value in the same edge.
module program_counter
    import rat_pkg::*;
#(
    parameter int unsigned          ADDR_W      = RAT_ADDR_W,
    parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
    parameter logic [ADDR_W-1:0]    INTR_VECTOR = RAT_INTR_VECTOR
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                ld,
    input  logic                inc,
    input  pc_sel_t             sel,
    input  logic [ADDR_W-1:0]   from_immed,
    input  logic [ADDR_W-1:0]   from_stack,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   pc_nxt
);

    always_comb begin
        pc_nxt = pc;
        if (ld) begin
            case (sel)
                PC_SEL_IMMED:  pc_nxt = from_immed;
                PC_SEL_STACK:  pc_nxt = from_stack;
                PC_SEL_VECTOR: pc_nxt = INTR_VECTOR;
                default:       pc_nxt = pc;
            endcase
        end else if (inc) begin
            pc_nxt = pc + ADDR_W'(1);   // wraps silently at the top of the ROM
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) pc <= RESET_PC;
        else        pc <= pc_nxt;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch sequencer FETCH->DECODE->EXEC in front of a registered ROM; 3 cycles/instr, PC->IR 2 cycles.
// STALL freezes EXEC (PC, IR held). Interrupt entry via the INTR state is built only with RAT_INTR_EN.
module pc_fetch_unit
    import rat_pkg::*;
#(
    parameter int unsigned          ADDR_W      = RAT_ADDR_W,
    parameter int unsigned          INSTR_W     = RAT_INSTR_W,
    parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
    parameter logic [ADDR_W-1:0]    INTR_VECTOR = RAT_INTR_VECTOR
) (
    input  logic                CLK,
    input  logic                RST_N,
    output logic [ADDR_W-1:0]   PROG_ADDR,
    input  logic [INSTR_W-1:0]  PROG_IR,
    output logic [INSTR_W-1:0]  IR,
    output logic                IR_VALID,
    input  logic                STALL,
    input  logic                PC_LD,
    input  logic                PC_INC,
    input  logic [1:0]          PC_MUX_SEL,
    input  logic [ADDR_W-1:0]   FROM_IMMED,
    input  logic [ADDR_W-1:0]   FROM_STACK,
    output logic [ADDR_W-1:0]   PC_COUNT,
    input  logic                INTR,
    output logic                INTR_ACK,
    output logic [ADDR_W-1:0]   RET_PC
);

    fetch_state_t        state_q;
    logic                exec_go;
    logic                pc_ld_en;
    logic                pc_inc_en;
    pc_sel_t             pc_sel;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pc_nxt;

    assign exec_go = (state_q == ST_EXEC) && !STALL;

    always_comb begin
        pc_ld_en  = exec_go && PC_LD;
        pc_inc_en = exec_go && PC_INC;
        pc_sel    = pc_sel_t'(PC_MUX_SEL);
`ifdef RAT_INTR_EN
        if (state_q == ST_INTR) begin
            pc_ld_en = 1'b1;
            pc_sel   = PC_SEL_VECTOR;
        end
`endif
    end

    program_counter #(
        .ADDR_W      (ADDR_W),
        .RESET_PC    (RESET_PC),
        .INTR_VECTOR (INTR_VECTOR)
    ) u_pc (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .ld         (pc_ld_en),
        .inc        (pc_inc_en),
        .sel        (pc_sel),
        .from_immed (FROM_IMMED),
        .from_stack (FROM_STACK),
        .pc         (pc),
        .pc_nxt     (pc_nxt)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_FETCH;
            IR      <= '0;
        end else begin
            case (state_q)
                ST_FETCH:  state_q <= ST_DECODE;
                ST_DECODE: begin
                    state_q <= ST_EXEC;
                    IR      <= PROG_IR;
                end
                ST_EXEC: begin
                    if (!STALL) begin
`ifdef RAT_INTR_EN
                        state_q <= INTR ? ST_INTR : ST_FETCH;
`else
                        state_q <= ST_FETCH;
`endif
                    end
                end
                default:   state_q <= ST_FETCH;
            endcase
        end
    end

    assign PROG_ADDR = pc;
    assign PC_COUNT  = pc;
    assign IR_VALID  = (state_q == ST_EXEC);

`ifdef RAT_INTR_EN
    // Resume point is the PC after this instruction's own update.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                RET_PC <= '0;
        else if (exec_go && INTR)  RET_PC <= pc_nxt;
    end

    assign INTR_ACK = (state_q == ST_INTR);
`else
    logic unused_intr;
    assign unused_intr = INTR;
    assign INTR_ACK    = 1'b0;
    assign RET_PC      = '0;
`endif

endmodule
